key_repeat_cond: RTL and testbench

Push-button conditioner for the 24-hour clock's time-set inputs. Synchronises and debounces one raw key input using the 1 kHz `ENABLE_khz` tick, and produces a clean level. It also produces one-cycle press pulses with auto-repeat while the key is held. It sits directly upstream of the clock top; its `KEY_PULSE` drives count-step inputs such as `DEC`, and its `KEY_LEVEL` drives mode inputs such as `SW`.

---
 rtl/key_repeat_cond.sv | 173 +++++++++++++++++
 tb/tb_key_repeat_cond.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/key_repeat_cond.sv
// key_repeat_cond: synchroniser, tick-based debouncer and press/auto-repeat pulse
// generator for one push button.
// Optional feature macro: KEY_REPEAT_EN (defined = IDLE/WAIT/REPEAT auto-repeat,
// undefined = single pulse per press with KEY_LONG tied low).
module key_repeat_cond #(
  parameter int unsigned DEB_MS       = 20,
  parameter int unsigned REP_DELAY_MS = 500,
  parameter int unsigned REP_RATE_MS  = 100
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ENABLE_khz,
  input  logic KEY_IN,
  output logic KEY_LEVEL,
  output logic KEY_PULSE,
  output logic KEY_LONG
);

  localparam int unsigned CNT_W = 10;

  // Reject parameter values the 10-bit counters cannot represent.
  if (DEB_MS < 1 || DEB_MS > 1023 || REP_DELAY_MS < 1 || REP_DELAY_MS > 1023 ||
      REP_RATE_MS < 1 || REP_RATE_MS > 1023) begin : g_param_check
    $error("key_repeat_cond: timing parameter outside 1..1023");
  end

  logic             sync_meta;
  logic             samp;
  logic [CNT_W-1:0] deb_cnt;
  logic             deb_done_c;
  logic             rise_c;
  logic             fall_c;
  logic             pulse_nxt;

  // Two-flop synchroniser; samp is the only view of the key used downstream.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_meta <= 1'b0;
      samp      <= 1'b0;
    end else begin
      sync_meta <= KEY_IN;
      samp      <= sync_meta;
    end
  end

  // Debounce completes on the tick where a changed sample has persisted DEB_MS ticks.
  assign deb_done_c = ENABLE_khz && (samp != KEY_LEVEL) && (deb_cnt == CNT_W'(DEB_MS - 1));
  assign rise_c     = deb_done_c && !KEY_LEVEL;
  assign fall_c     = deb_done_c && KEY_LEVEL;

  // Debounce counter and debounced level, advancing on ticks only.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      deb_cnt   <= '0;
      KEY_LEVEL <= 1'b0;
    end else if (ENABLE_khz) begin
      if (samp == KEY_LEVEL) begin
        deb_cnt <= '0;
      end else if (deb_done_c) begin
        deb_cnt   <= '0;
        KEY_LEVEL <= ~KEY_LEVEL;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end
  end

`ifdef KEY_REPEAT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_REPEAT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] rep_cnt_nxt;
  logic             long_nxt;

  // State, repeat counter and registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      rep_cnt   <= '0;
      KEY_PULSE <= 1'b0;
      KEY_LONG  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rep_cnt   <= rep_cnt_nxt;
      KEY_PULSE <= pulse_nxt & ~KEY_PULSE;
      KEY_LONG  <= long_nxt;
    end
  end

  // Press pulse on the level rise, then delayed and periodic repeat pulses; release wins.
  always_comb begin
    state_nxt   = state;
    rep_cnt_nxt = rep_cnt;
    pulse_nxt   = 1'b0;
    long_nxt    = KEY_LONG;
    if (fall_c) begin
      state_nxt   = ST_IDLE;
      rep_cnt_nxt = '0;
      long_nxt    = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise_c) begin
            pulse_nxt   = 1'b1;
            rep_cnt_nxt = '0;
            state_nxt   = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ENABLE_khz) begin
            if (rep_cnt == CNT_W'(REP_DELAY_MS - 1)) begin
              pulse_nxt   = 1'b1;
              long_nxt    = 1'b1;
              rep_cnt_nxt = '0;
              state_nxt   = ST_REPEAT;
            end else begin
              rep_cnt_nxt = rep_cnt + CNT_W'(1);
            end
          end
        end
        ST_REPEAT: begin
          if (ENABLE_khz) begin
            if (rep_cnt == CNT_W'(REP_RATE_MS - 1)) begin
              pulse_nxt   = 1'b1;
              rep_cnt_nxt = '0;
            end else begin
              rep_cnt_nxt = rep_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state_nxt   = ST_IDLE;
          rep_cnt_nxt = '0;
          long_nxt    = 1'b0;
        end
      endcase
    end
  end
`else
  typedef enum logic {ST_IDLE, ST_HELD} state_t;

  state_t state;
  state_t state_nxt;

  // State and registered press pulse.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      KEY_PULSE <= 1'b0;
    end else begin
      state     <= state_nxt;
      KEY_PULSE <= pulse_nxt & ~KEY_PULSE;
    end
  end

  // Exactly one pulse per debounced press; release returns to IDLE silently.
  always_comb begin
    state_nxt = state;
    pulse_nxt = 1'b0;
    if (fall_c) begin
      state_nxt = ST_IDLE;
    end else if (state == ST_IDLE && rise_c) begin
      pulse_nxt = 1'b1;
      state_nxt = ST_HELD;
    end
  end

  assign KEY_LONG = 1'b0;
`endif

endmodule

// File: tb/tb_key_repeat_cond.sv
// Self-checking bench for key_repeat_cond: directed segment table, reset-mid-hold
// sequence and randomized key activity against a behavioural model.
module tb_key_repeat_cond;

  localparam int unsigned DEB  = 3;
  localparam int unsigned DLY  = 5;
  localparam int unsigned RATE = 2;
  localparam int DEB_I  = 3;
  localparam int DLY_I  = 5;
  localparam int RATE_I = 2;
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic ENABLE_khz = 1'b0;
  logic KEY_IN = 1'b0;
  logic KEY_LEVEL;
  logic KEY_PULSE;
  logic KEY_LONG;

  key_repeat_cond #(
    .DEB_MS(DEB),
    .REP_DELAY_MS(DLY),
    .REP_RATE_MS(RATE)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .ENABLE_khz(ENABLE_khz),
    .KEY_IN(KEY_IN),
    .KEY_LEVEL(KEY_LEVEL),
    .KEY_PULSE(KEY_PULSE),
    .KEY_LONG(KEY_LONG)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int seg_pulses = 0;

  // Behavioural model: sample pipeline, run length of differing ticks, ticks held since press.
  logic m_s1, m_s, m_level, m_pulse, m_long;
  int   m_run, m_held;

  typedef struct {
    logic key;
    logic tick_en;
    int   n;
    int   exp_pulses;
    logic exp_level;
    logic exp_long;
  } seg_t;

  seg_t segs[$];

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b0; m_s = 1'b0; m_level = 1'b0; m_pulse = 1'b0; m_long = 1'b0;
    m_run = 0; m_held = -1;
  endtask

  task automatic model_step(input logic k, input logic t);
    logic old_level;
    logic prev_pulse;
    logic p;
    old_level  = m_level;
    prev_pulse = m_pulse;
    if (t) begin
      if (m_s != m_level) begin
        m_run++;
        if (m_run == DEB_I) begin
          m_level = !m_level;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    m_s  = m_s1;
    m_s1 = k;
    p = 1'b0;
    if (old_level && !m_level) begin
      m_held = -1;
      m_long = 1'b0;
    end else if (!old_level && m_level) begin
      p = 1'b1;
      m_held = 0;
    end else if (REP_EN && m_held >= 0 && t) begin
      m_held++;
      if (m_held == DLY_I || (m_held > DLY_I && ((m_held - DLY_I) % RATE_I) == 0)) p = 1'b1;
      m_long = (m_held >= DLY_I);
    end
    m_pulse = p && !prev_pulse;
  endtask

  task automatic step(input logic k, input logic t);
    KEY_IN = k;
    ENABLE_khz = t;
    @(posedge CLK);
    if (RESET) model_step(k, t);
    else model_reset();
    #1;
    chk_bit("cyc_level", KEY_LEVEL, m_level);
    chk_bit("cyc_pulse", KEY_PULSE, m_pulse);
    chk_bit("cyc_long", KEY_LONG, m_long);
    if (KEY_PULSE === 1'b1) seg_pulses++;
  endtask

  // One tick period: three idle cycles then the tick cycle.
  task automatic period(input logic k, input logic en);
    repeat (3) step(k, 1'b0);
    step(k, en);
  endtask

  initial begin
    model_reset();

    // Bounce rejection
    segs.push_back('{1'b1, 1'b1, 2, 0, 1'b0, 1'b0});
    segs.push_back('{1'b0, 1'b1, 1, 0, 1'b0, 1'b0});
    segs.push_back('{1'b1, 1'b1, 3, 1, 1'b1, 1'b0});
    // Short press: one more tick held, release falls at offset 4
    segs.push_back('{1'b1, 1'b1, 1, 0, 1'b1, 1'b0});
    segs.push_back('{1'b0, 1'b1, 3, 0, 1'b0, 1'b0});
    // Release fall coincides with the first-repeat tick: no pulse
    segs.push_back('{1'b1, 1'b1, 3, 1, 1'b1, 1'b0});
    segs.push_back('{1'b1, 1'b1, 2, 0, 1'b1, 1'b0});
    segs.push_back('{1'b0, 1'b1, 3, 0, 1'b0, 1'b0});
    // Long hold: repeats at offsets 5,7,9,11 held, 13 during release
    segs.push_back('{1'b1, 1'b1, 3, 1, 1'b1, 1'b0});
    segs.push_back('{1'b1, 1'b1, 12, REP_EN ? 4 : 0, 1'b1, REP_EN});
    segs.push_back('{1'b0, 1'b1, 3, REP_EN ? 1 : 0, 1'b0, 1'b0});
    // No ticks: key pressed forever without effect
    segs.push_back('{1'b1, 1'b0, 20, 0, 1'b0, 1'b0});
    segs.push_back('{1'b0, 1'b1, 2, 0, 1'b0, 1'b0});
    // Debounce count holds across tickless gap
    segs.push_back('{1'b1, 1'b1, 2, 0, 1'b0, 1'b0});
    segs.push_back('{1'b1, 1'b0, 5, 0, 1'b0, 1'b0});
    segs.push_back('{1'b1, 1'b1, 1, 1, 1'b1, 1'b0});
    segs.push_back('{1'b0, 1'b1, 3, 0, 1'b0, 1'b0});

    // Reset state
    repeat (3) step(1'b0, 1'b0);
    chk_bit("rst_level", KEY_LEVEL, 1'b0);
    chk_bit("rst_pulse", KEY_PULSE, 1'b0);
    chk_bit("rst_long", KEY_LONG, 1'b0);
    RESET = 1'b1;
    repeat (2) period(1'b0, 1'b1);

    foreach (segs[i]) begin
      seg_pulses = 0;
      repeat (segs[i].n) period(segs[i].key, segs[i].tick_en);
      chk_int($sformatf("seg%0d_pulses", i), seg_pulses, segs[i].exp_pulses);
      chk_bit($sformatf("seg%0d_level", i), KEY_LEVEL, segs[i].exp_level);
      chk_bit($sformatf("seg%0d_long", i), KEY_LONG, segs[i].exp_long);
    end

    // Reset asserted mid-hold while in the repeat phase
    repeat (3) period(1'b1, 1'b1);
    repeat (6) period(1'b1, 1'b1);
    chk_bit("hold_long", KEY_LONG, REP_EN);
    chk_bit("hold_level", KEY_LEVEL, 1'b1);
    #2;
    RESET = 1'b0;
    #1;
    chk_bit("async_rst_level", KEY_LEVEL, 1'b0);
    chk_bit("async_rst_pulse", KEY_PULSE, 1'b0);
    chk_bit("async_rst_long", KEY_LONG, 1'b0);
    model_reset();
    repeat (2) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    RESET = 1'b1;
    seg_pulses = 0;
    repeat (2) period(1'b1, 1'b1);
    chk_bit("rel_mid_level", KEY_LEVEL, 1'b0);
    period(1'b1, 1'b1);
    chk_int("rel_press_pulses", seg_pulses, 1);
    chk_bit("rel_press_level", KEY_LEVEL, 1'b1);
    repeat (3) period(1'b0, 1'b1);
    chk_bit("rel_release_level", KEY_LEVEL, 1'b0);

    // Randomized key runs with occasional single-cycle glitches between ticks
    for (int i = 0; i < 60; i++) begin
      logic k;
      int   n;
      k = 1'($urandom_range(0, 1));
      n = int'($urandom_range(1, 14));
      for (int j = 0; j < n; j++) begin
        for (int c = 0; c < 3; c++) begin
          step(($urandom_range(0, 9) == 0) ? !k : k, 1'b0);
        end
        step(k, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
